// File: rtl/cook_time_entry.sv
// Cook-time digit editor: mode/up/down buttons select and step four BCD
// digits (mm:ss) that time_count loads. It supports auto-repeat while a
// button is held and a blink strobe for the selected digit. Editing is
// locked out while the timer is running.
module cook_time_entry #(
   parameter int REPEAT_DELAY = 3,
   parameter int REPEAT_RATE  = 1,
   parameter int MAX_TENS     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       timer_running,
   output logic [3:0] seconds_prog,
   output logic [3:0] tens_seconds_prog,
   output logic [3:0] minutes_prog,
   output logic [3:0] tens_minutes_prog,
   output logic       editing,
   output logic [1:0] edit_digit,
   output logic       blink
);

   localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
   // The counter reaching REPEAT_DELAY on this tick means it currently holds REPEAT_DELAY-1.
   localparam logic [CNT_W-1:0] FIRE_AT   = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
   localparam logic [3:0]       UNITS_MAX = 4'd9;
   localparam logic [3:0]       TENS_MAX  = 4'(MAX_TENS);

   typedef enum logic [2:0] {IDLE, EDIT_S, EDIT_TS, EDIT_M, EDIT_TM} state_t;

   state_t           state;
   logic             mode_q, up_q, down_q;
   logic [CNT_W-1:0] rep_cnt;

   logic mode_rise, up_rise, down_rise;
   logic in_edit, act, one_held, rep_fire, step_up, step_down;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
      return (d >= lim) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] lim);
      return (d == 4'd0 || d > lim) ? lim : d - 4'd1;
   endfunction

   function automatic state_t next_edit(input state_t s);
      case (s)
         IDLE:    return EDIT_S;
         EDIT_S:  return EDIT_TS;
         EDIT_TS: return EDIT_M;
         EDIT_M:  return EDIT_TM;
         default: return IDLE;
      endcase
   endfunction

   function automatic logic [1:0] digit_of(input state_t s);
      case (s)
         EDIT_TS: return 2'd1;
         EDIT_M:  return 2'd2;
         EDIT_TM: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   assign mode_rise = btn_mode & ~mode_q;
   assign up_rise   = btn_up   & ~up_q;
   assign down_rise = btn_down & ~down_q;
   assign in_edit   = (state != IDLE);
   // Stepping is allowed only in an edit state, unlocked, and when mode is not advancing.
   assign act       = in_edit & ~timer_running & ~mode_rise;
   assign one_held  = btn_up ^ btn_down;
   assign rep_fire  = act & tick & one_held & (rep_cnt >= FIRE_AT);
   assign step_up   = act & ((up_rise   & ~btn_down) | (rep_fire & btn_up));
   assign step_down = act & ((down_rise & ~btn_up)   | (rep_fire & btn_down));

   // Button history for rise detection; tracks buttons even while locked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q <= 1'b0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
      end else begin
         mode_q <= btn_mode;
         up_q   <= btn_up;
         down_q <= btn_down;
      end
   end

   // Edit FSM with registered editing/edit_digit/blink and the auto-repeat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         editing    <= 1'b0;
         edit_digit <= 2'd0;
         blink      <= 1'b1;
         rep_cnt    <= '0;
      end else begin
         if (timer_running) begin
            state      <= IDLE;
            editing    <= 1'b0;
            edit_digit <= 2'd0;
            blink      <= 1'b1;
         end else if (mode_rise) begin
            state      <= next_edit(state);
            editing    <= (next_edit(state) != IDLE);
            edit_digit <= digit_of(next_edit(state));
            blink      <= 1'b1;
         end else if (!in_edit) begin
            blink <= 1'b1;
         end else if (tick) begin
            blink <= ~blink;
         end

         if (!act || !one_held) begin
            rep_cnt <= '0;
         end else if (tick) begin
            rep_cnt <= rep_fire ? RELOAD : rep_cnt + CNT_W'(1);
         end
      end
   end

   // Step the selected digit with BCD wrap; no carry between digits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seconds_prog      <= 4'd0;
         tens_seconds_prog <= 4'd0;
         minutes_prog      <= 4'd0;
         tens_minutes_prog <= 4'd0;
      end else if (step_up || step_down) begin
         case (state)
            EDIT_S:  seconds_prog      <= step_up ? bcd_inc(seconds_prog, UNITS_MAX)
                                                  : bcd_dec(seconds_prog, UNITS_MAX);
            EDIT_TS: tens_seconds_prog <= step_up ? bcd_inc(tens_seconds_prog, TENS_MAX)
                                                  : bcd_dec(tens_seconds_prog, TENS_MAX);
            EDIT_M:  minutes_prog      <= step_up ? bcd_inc(minutes_prog, UNITS_MAX)
                                                  : bcd_dec(minutes_prog, UNITS_MAX);
            EDIT_TM: tens_minutes_prog <= step_up ? bcd_inc(tens_minutes_prog, TENS_MAX)
                                                  : bcd_dec(tens_minutes_prog, TENS_MAX);
            default: ;
         endcase
      end
   end

endmodule
